// File: rtl/load_store_buffer.sv
// load_store_buffer
//   In-order load/store queue between the instruction unit and the memory
//   controller. Entries are issued by the instruction unit. Waiting operands
//   are captured from the ALU broadcast (rs*) and from this unit's own
//   completion broadcast (lsb*). The head entry accesses memory strictly in
//   FIFO order. A store is sent to memory only when it is the ROB head.
//
// Ports
//   clockIn, resetIn         clock; synchronous active-high reset
//   clear                    flush from the ROB on a misprediction
//   add*                     issue interface; full = no free entry
//   rs*                      ALU result broadcast
//   robBeginId               ROB head index
//   mem*                     request/response to the memory controller
//   lsbUpdate/RobIndex/Val   completion pulse to the ROB and operand waiters
module load_store_buffer #(
  parameter int LSB_WIDTH = 3,
  parameter int LSB_SIZE  = 2 ** LSB_WIDTH,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clear,
  input  logic                 addValid,
  input  logic                 addIsStore,
  input  logic [2:0]           addFunct3,
  input  logic                 addBaseReady,
  input  logic [31:0]          addBaseVal,
  input  logic [ROB_WIDTH-1:0] addBaseDep,
  input  logic                 addDataReady,
  input  logic [31:0]          addDataVal,
  input  logic [ROB_WIDTH-1:0] addDataDep,
  input  logic [11:0]          addOffset,
  input  logic [ROB_WIDTH-1:0] addRobIndex,
  output logic                 full,
  input  logic                 rsUpdate,
  input  logic [ROB_WIDTH-1:0] rsRobIndex,
  input  logic [31:0]          rsUpdateVal,
  input  logic [ROB_WIDTH-1:0] robBeginId,
  output logic                 memReq,
  output logic                 memWrite,
  output logic [31:0]          memAddr,
  output logic [1:0]           memSize,
  output logic [31:0]          memWData,
  input  logic                 memDone,
  input  logic [31:0]          memRData,
  output logic                 lsbUpdate,
  output logic [ROB_WIDTH-1:0] lsbRobIndex,
  output logic [31:0]          lsbUpdateVal
);

  typedef struct packed {
    logic                 valid;
    logic                 is_store;
    logic [2:0]           funct3;
    logic                 base_ready;
    logic [31:0]          base_val;
    logic [ROB_WIDTH-1:0] base_dep;
    logic                 data_ready;
    logic [31:0]          data_val;
    logic [ROB_WIDTH-1:0] data_dep;
    logic [11:0]          offset;
    logic [ROB_WIDTH-1:0] rob_index;
  } entry_t;

  // DRAIN: a flushed load is still outstanding at the memory controller and
  // its response must be absorbed before the next request goes out.
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t               state_reg;
  entry_t               entry_reg  [LSB_SIZE];
  entry_t               entry_next [LSB_SIZE];
  logic [LSB_WIDTH-1:0] head_reg;
  logic [LSB_WIDTH-1:0] tail_reg;
  logic [LSB_WIDTH:0]   count_reg;

  // Attributes of the access in flight, kept apart from the queue so that a
  // flush cannot lose the store that is still completing.
  logic                 cur_store_reg;
  logic [2:0]           cur_funct3_reg;
  logic [ROB_WIDTH-1:0] cur_rob_reg;
  // Set when a flush hit while a store was in flight: its entry is gone, so
  // completion must report but must not pop the (already reset) queue.
  logic                 orphan_reg;

  entry_t head_entry;
  entry_t add_raw;
  entry_t add_entry;
  logic   head_ready;
  logic   do_add;
  logic   do_pop;
  logic   issue;

  // Capture a broadcast into any operand still waiting on its tag; the ALU
  // bus wins when both buses carry the tag.
  function automatic entry_t snoop(
    input entry_t               e,
    input logic                 rs_v,
    input logic [ROB_WIDTH-1:0] rs_tag,
    input logic [31:0]          rs_val,
    input logic                 lsb_v,
    input logic [ROB_WIDTH-1:0] lsb_tag,
    input logic [31:0]          lsb_val
  );
    entry_t r;
    r = e;
    if (!e.base_ready) begin
      if (rs_v && rs_tag == e.base_dep) begin
        r.base_ready = 1'b1;
        r.base_val   = rs_val;
      end else if (lsb_v && lsb_tag == e.base_dep) begin
        r.base_ready = 1'b1;
        r.base_val   = lsb_val;
      end
    end
    if (!e.data_ready) begin
      if (rs_v && rs_tag == e.data_dep) begin
        r.data_ready = 1'b1;
        r.data_val   = rs_val;
      end else if (lsb_v && lsb_tag == e.data_dep) begin
        r.data_ready = 1'b1;
        r.data_val   = lsb_val;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b100:  r = {24'b0, d[7:0]};
      3'b101:  r = {16'b0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // New entry, including same-cycle bypass from either broadcast bus.
  always_comb begin
    add_raw            = '0;
    add_raw.valid      = 1'b1;
    add_raw.is_store   = addIsStore;
    add_raw.funct3     = addFunct3;
    add_raw.base_ready = addBaseReady;
    add_raw.base_val   = addBaseVal;
    add_raw.base_dep   = addBaseDep;
    add_raw.data_ready = addDataReady;
    add_raw.data_val   = addDataVal;
    add_raw.data_dep   = addDataDep;
    add_raw.offset     = addOffset;
    add_raw.rob_index  = addRobIndex;
    add_entry = snoop(add_raw, rsUpdate, rsRobIndex, rsUpdateVal,
                      lsbUpdate, lsbRobIndex, lsbUpdateVal);
  end

  assign head_entry = entry_reg[head_reg];
  assign head_ready = head_entry.valid && head_entry.base_ready &&
                      (!head_entry.is_store ||
                       (head_entry.data_ready && head_entry.rob_index == robBeginId));
  assign full   = (count_reg == (LSB_WIDTH + 1)'(LSB_SIZE));
  assign do_add = addValid && !full && !clear;
  assign issue  = (state_reg == IDLE) && head_ready && !clear;
  assign do_pop = (state_reg == WAIT) && memDone && !orphan_reg && !clear;

  genvar gi;
  generate
    for (gi = 0; gi < LSB_SIZE; gi++) begin : g_entry
      // Add and pop never target the same slot: that would need head==tail
      // with a non-empty queue, i.e. full, where the add is refused.
      assign entry_next[gi] =
        (do_add && tail_reg == LSB_WIDTH'(gi)) ? add_entry :
        (do_pop && head_reg == LSB_WIDTH'(gi)) ? entry_t'('0) :
        snoop(entry_reg[gi], rsUpdate, rsRobIndex, rsUpdateVal,
              lsbUpdate, lsbRobIndex, lsbUpdateVal);
    end
  endgenerate

  always_ff @(posedge clockIn) begin
    if (resetIn || clear) begin
      for (int i = 0; i < LSB_SIZE; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < LSB_SIZE; i++) entry_reg[i] <= entry_next[i];
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_reg      <= IDLE;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      memReq         <= 1'b0;
      memWrite       <= 1'b0;
      memAddr        <= '0;
      memSize        <= '0;
      memWData       <= '0;
      lsbUpdate      <= 1'b0;
      lsbRobIndex    <= '0;
      lsbUpdateVal   <= '0;
      cur_store_reg  <= 1'b0;
      cur_funct3_reg <= '0;
      cur_rob_reg    <= '0;
      orphan_reg     <= 1'b0;
    end else begin
      lsbUpdate <= 1'b0;

      if (clear) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (do_pop) head_reg <= head_reg + 1'b1;
        if (do_add) tail_reg <= tail_reg + 1'b1;
        case ({do_add, do_pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end

      case (state_reg)
        IDLE: begin
          if (issue) begin
            memReq         <= 1'b1;
            memWrite       <= head_entry.is_store;
            memAddr        <= head_entry.base_val +
                              {{20{head_entry.offset[11]}}, head_entry.offset};
            // funct3[1:0] already encodes byte/half/word for both signednesses.
            memSize        <= head_entry.funct3[1:0];
            memWData       <= head_entry.is_store ? head_entry.data_val : 32'b0;
            cur_store_reg  <= head_entry.is_store;
            cur_funct3_reg <= head_entry.funct3;
            cur_rob_reg    <= head_entry.rob_index;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          if (memDone) begin
            memReq     <= 1'b0;
            state_reg  <= IDLE;
            orphan_reg <= 1'b0;
            // A store is non-speculative, so it reports even across a flush.
            if (cur_store_reg || !clear) begin
              lsbUpdate    <= 1'b1;
              lsbRobIndex  <= cur_rob_reg;
              lsbUpdateVal <= cur_store_reg ? 32'b0 : load_ext(memRData, cur_funct3_reg);
            end
          end else if (clear) begin
            if (cur_store_reg) orphan_reg <= 1'b1;
            else               state_reg  <= DRAIN;
          end
        end
        DRAIN: begin
          if (memDone) begin
            memReq    <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Testbench for load_store_buffer: directed stimulus, expectations queued at
// issue time, independent monitor comparing memory requests and completions.
module tb_load_store_buffer;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        clear;
  logic        addValid;
  logic        addIsStore;
  logic [2:0]  addFunct3;
  logic        addBaseReady;
  logic [31:0] addBaseVal;
  logic [3:0]  addBaseDep;
  logic        addDataReady;
  logic [31:0] addDataVal;
  logic [3:0]  addDataDep;
  logic [11:0] addOffset;
  logic [3:0]  addRobIndex;
  logic        full;
  logic        rsUpdate;
  logic [3:0]  rsRobIndex;
  logic [31:0] rsUpdateVal;
  logic [3:0]  robBeginId;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [1:0]  memSize;
  logic [31:0] memWData;
  logic        memDone;
  logic [31:0] memRData;
  logic        lsbUpdate;
  logic [3:0]  lsbRobIndex;
  logic [31:0] lsbUpdateVal;

  load_store_buffer #(.LSB_WIDTH(3), .LSB_SIZE(8), .ROB_WIDTH(4)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .clear(clear),
    .addValid(addValid), .addIsStore(addIsStore), .addFunct3(addFunct3),
    .addBaseReady(addBaseReady), .addBaseVal(addBaseVal), .addBaseDep(addBaseDep),
    .addDataReady(addDataReady), .addDataVal(addDataVal), .addDataDep(addDataDep),
    .addOffset(addOffset), .addRobIndex(addRobIndex), .full(full),
    .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex), .rsUpdateVal(rsUpdateVal),
    .robBeginId(robBeginId),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memSize(memSize),
    .memWData(memWData), .memDone(memDone), .memRData(memRData),
    .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal)
  );

  always #5 clockIn = ~clockIn;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
  } upd_t;

  req_t        exp_req[$];
  upd_t        exp_upd[$];
  logic [31:0] rdata_q[$];
  int          done_delay = 2;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares each new memory request and each completion pulse.
  initial begin
    logic seen;
    req_t e;
    upd_t u;
    seen = 1'b0;
    forever begin
      @(negedge clockIn);
      if (!resetIn) begin
        if (memReq && !seen) begin
          $display("req  write=%0b addr=0x%08h size=%0d wdata=0x%08h", memWrite, memAddr, memSize, memWData);
          if (exp_req.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
          end else begin
            e = exp_req.pop_front();
            check("req_write", 32'(memWrite), 32'(e.w));
            check("req_addr", memAddr, e.addr);
            check("req_size", 32'(memSize), 32'(e.size));
            check("req_wdata", memWData, e.wdata);
          end
        end
        seen = memReq;
        if (lsbUpdate) begin
          $display("done rob=%0d val=0x%08h", lsbRobIndex, lsbUpdateVal);
          if (exp_upd.size() == 0) begin
            check("unexpected_update", 32'd1, 32'd0);
          end else begin
            u = exp_upd.pop_front();
            check("upd_rob", 32'(lsbRobIndex), 32'(u.rob));
            check("upd_val", lsbUpdateVal, u.val);
          end
        end
      end
    end
  end

  // Memory model: answers each request after done_delay cycles.
  initial begin
    memDone  = 1'b0;
    memRData = '0;
    forever begin
      @(negedge clockIn);
      if (memReq && !resetIn) begin
        repeat (done_delay) @(negedge clockIn);
        memRData = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
        memDone  = 1'b1;
        @(negedge clockIn);
        memDone  = 1'b0;
        memRData = '0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic st, input logic [2:0] f3,
                     input logic br, input logic [31:0] bv, input logic [3:0] bd,
                     input logic dr, input logic [31:0] dv, input logic [3:0] dd,
                     input logic [11:0] off, input logic [3:0] rob);
    addValid = 1'b1; addIsStore = st; addFunct3 = f3;
    addBaseReady = br; addBaseVal = bv; addBaseDep = bd;
    addDataReady = dr; addDataVal = dv; addDataDep = dd;
    addOffset = off; addRobIndex = rob;
    @(negedge clockIn);
    addValid = 1'b0;
  endtask

  task automatic expect_load(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] rdata, input logic [3:0] rob,
                             input logic [31:0] val);
    exp_req.push_back('{1'b0, addr, size, 32'h0});
    rdata_q.push_back(rdata);
    exp_upd.push_back('{rob, val});
  endtask

  task automatic expect_store(input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata, input logic [3:0] rob);
    exp_req.push_back('{1'b1, addr, size, wdata});
    rdata_q.push_back(32'h0);
    exp_upd.push_back('{rob, 32'h0});
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((exp_req.size() != 0 || exp_upd.size() != 0 || memReq) && cyc < 300) begin
      @(negedge clockIn);
      cyc++;
    end
    repeat (2) @(negedge clockIn);
    check(name, 32'(exp_req.size() + exp_upd.size()), 32'd0);
  endtask

  initial begin
    resetIn = 1'b1; clear = 1'b0; addValid = 1'b0; addIsStore = 1'b0;
    addFunct3 = '0; addBaseReady = 1'b0; addBaseVal = '0; addBaseDep = '0;
    addDataReady = 1'b0; addDataVal = '0; addDataDep = '0; addOffset = '0;
    addRobIndex = '0; rsUpdate = 1'b0; rsRobIndex = '0; rsUpdateVal = '0;
    robBeginId = '0;
    repeat (3) @(negedge clockIn);
    check("rst_memReq", 32'(memReq), 32'd0);
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_memAddr", memAddr, 32'd0);
    check("rst_memSize", 32'(memSize), 32'd0);
    check("rst_memWData", memWData, 32'd0);
    check("rst_lsbUpdate", 32'(lsbUpdate), 32'd0);
    check("rst_lsbRobIndex", 32'(lsbRobIndex), 32'd0);
    check("rst_lsbUpdateVal", lsbUpdateVal, 32'd0);
    check("rst_full", 32'(full), 32'd0);
    resetIn = 1'b0;
    @(negedge clockIn);

    // 1: lw from 0x100 - 4
    expect_load(32'h0FC, 2'b10, 32'hDEADBEEF, 4'd1, 32'hDEADBEEF);
    add(1'b0, 3'b010, 1'b1, 32'h100, 4'd0, 1'b0, 32'h0, 4'd0, 12'hFFC, 4'd1);
    wait_idle("t1_drain");

    // 2: byte/half loads with sign and zero extension, issued back to back
    expect_load(32'h301, 2'b00, 32'h00000080, 4'd2, 32'hFFFFFF80);
    expect_load(32'h302, 2'b00, 32'h00000080, 4'd3, 32'h00000080);
    expect_load(32'h304, 2'b01, 32'hFFFFF234, 4'd4, 32'h0000F234);
    expect_load(32'h306, 2'b01, 32'h12348001, 4'd6, 32'hFFFF8001);
    add(1'b0, 3'b000, 1'b1, 32'h300, 4'd0, 1'b0, 32'h0, 4'd0, 12'h001, 4'd2);
    add(1'b0, 3'b100, 1'b1, 32'h300, 4'd0, 1'b0, 32'h0, 4'd0, 12'h002, 4'd3);
    add(1'b0, 3'b101, 1'b1, 32'h300, 4'd0, 1'b0, 32'h0, 4'd0, 12'h004, 4'd4);
    add(1'b0, 3'b001, 1'b1, 32'h300, 4'd0, 1'b0, 32'h0, 4'd0, 12'h006, 4'd6);
    wait_idle("t2_drain");

    // 3: store waits until it is the ROB head
    robBeginId = 4'd3;
    add(1'b1, 3'b010, 1'b1, 32'h400, 4'd0, 1'b1, 32'h12345678, 4'd0, 12'h008, 4'd5);
    for (int i = 0; i < 4; i++) begin
      check("t3_store_held", 32'(memReq), 32'd0);
      @(negedge clockIn);
    end
    expect_store(32'h408, 2'b10, 32'h12345678, 4'd5);
    robBeginId = 4'd5;
    @(negedge clockIn);
    check("t3_store_req_latency", 32'(memReq), 32'd1);
    wait_idle("t3_drain");

    // 4: base bypassed from the ALU bus in the add cycle; a store whose data
    //    comes from the load's own completion broadcast
    robBeginId = 4'd9;
    expect_load(32'h210, 2'b10, 32'h0BADF00D, 4'd8, 32'h0BADF00D);
    expect_store(32'h500, 2'b10, 32'h0BADF00D, 4'd9);
    rsUpdate = 1'b1; rsRobIndex = 4'd7; rsUpdateVal = 32'h200;
    add(1'b0, 3'b010, 1'b0, 32'h0, 4'd7, 1'b0, 32'h0, 4'd0, 12'h010, 4'd8);
    rsUpdate = 1'b0;
    check("t4_no_req_yet", 32'(memReq), 32'd0);
    add(1'b1, 3'b010, 1'b1, 32'h500, 4'd0, 1'b0, 32'h0, 4'd8, 12'h000, 4'd9);
    check("t4_bypass_latency", 32'(memReq), 32'd1);
    wait_idle("t4_drain");

    // 5: fill, drop when full, wrap, simultaneous add and pop
    for (int i = 0; i < 8; i++)
      expect_load(32'h1000 + 32'(i * 4), 2'b10, 32'hA0000000 + 32'(i), 4'(i), 32'hA0000000 + 32'(i));
    add(1'b0, 3'b010, 1'b0, 32'h0, 4'd10, 1'b0, 32'h0, 4'd0, 12'h000, 4'd0);
    for (int i = 1; i < 8; i++)
      add(1'b0, 3'b010, 1'b1, 32'h1000, 4'd0, 1'b0, 32'h0, 4'd0, 12'(i * 4), 4'(i));
    check("t5_full", 32'(full), 32'd1);
    add(1'b0, 3'b010, 1'b1, 32'h9990, 4'd0, 1'b0, 32'h0, 4'd0, 12'h000, 4'd11);
    check("t5_full_after_drop", 32'(full), 32'd1);
    rsUpdate = 1'b1; rsRobIndex = 4'd10; rsUpdateVal = 32'h1000;
    @(negedge clockIn);
    rsUpdate = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (full && cyc < 100) begin @(negedge clockIn); cyc++; end
      check("t5_first_pop", 32'(full), 32'd0);
      expect_load(32'h2000, 2'b10, 32'hB0000000, 4'd12, 32'hB0000000);
      add(1'b0, 3'b010, 1'b1, 32'h2000, 4'd0, 1'b0, 32'h0, 4'd0, 12'h000, 4'd12);
      check("t5_full_after_wrap", 32'(full), 32'd1);
      cyc = 0;
      while (full && cyc < 100) begin @(negedge clockIn); cyc++; end
      check("t5_second_pop", 32'(full), 32'd0);
      cyc = 0;
      do begin
        @(negedge clockIn);
        #1;
        cyc++;
      end while (!memDone && cyc < 100);
      check("t5_done_seen", 32'(memDone), 32'd1);
      expect_load(32'h3000, 2'b10, 32'hC0000000, 4'd13, 32'hC0000000);
      add(1'b0, 3'b010, 1'b1, 32'h3000, 4'd0, 1'b0, 32'h0, 4'd0, 12'h000, 4'd13);
      check("t5_pop_add_count", 32'(full), 32'd0);
      expect_load(32'h4000, 2'b10, 32'hD0000000, 4'd14, 32'hD0000000);
      add(1'b0, 3'b010, 1'b1, 32'h4000, 4'd0, 1'b0, 32'h0, 4'd0, 12'h000, 4'd14);
      check("t5_full_again", 32'(full), 32'd1);
    end
    wait_idle("t5_drain");

    // 6: flush while a load is outstanding
    done_delay = 6;
    exp_req.push_back('{1'b0, 32'h700, 2'b10, 32'h0});
    rdata_q.push_back(32'h55555555);
    add(1'b0, 3'b010, 1'b1, 32'h700, 4'd0, 1'b0, 32'h0, 4'd0, 12'h000, 4'd1);
    begin
      int cyc;
      cyc = 0;
      while (!memReq && cyc < 20) begin @(negedge clockIn); cyc++; end
    end
    check("t6_req_up", 32'(memReq), 32'd1);
    clear = 1'b1;
    add(1'b0, 3'b010, 1'b1, 32'h900, 4'd0, 1'b0, 32'h0, 4'd0, 12'h000, 4'd3);
    clear = 1'b0;
    check("t6_drain_hold", 32'(memReq), 32'd1);
    check("t6_count_zero", 32'(full), 32'd0);
    expect_load(32'h804, 2'b10, 32'h11112222, 4'd2, 32'h11112222);
    add(1'b0, 3'b010, 1'b1, 32'h800, 4'd0, 1'b0, 32'h0, 4'd0, 12'h004, 4'd2);
    check("t6_still_drain", 32'(memReq), 32'd1);
    check("t6_drain_addr", memAddr, 32'h700);
    wait_idle("t6_drain");
    done_delay = 2;

    check("end_lsbUpdate", 32'(lsbUpdate), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
